regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
Parametrised successor to the 8x8 CPU register file. Data width and depth are configurable. It has two asynchronous read ports and one synchronous write port, with write-to-read bypass. Reset-time initialisation is done by a sequential walker instead of a parallel load. It sits in the datapath between decode (register addresses) and the ALU/writeback stage.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 3, register address width. DEPTH = 2**ADDR_W registers (derived localparam, not overridable).

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset; restarts the init walker.
- read_reg1, input, ADDR_W, read port 1 address.
- read_reg2, input, ADDR_W, read port 2 address.
- write_reg, input, ADDR_W, write address.
- write_data, input, DATA_W, write data.
- regwrite, input, 1, write enable; sampled on rising clk.
- read_data1, output, DATA_W, read port 1 data (combinational).
- read_data2, output, DATA_W, read port 2 data (combinational).
- init_done, output, 1, high once all registers hold their init values and the file accepts writes.

Behaviour:
- State machine: INIT and RUN. State, walker index idx and init_done are registered.
- rst=1 at a clk edge: state<=INIT, idx<=0, init_done<=0. No storage write happens that cycle. rst held high keeps the walker parked at idx=0.
- INIT, rst=0, each edge:
  - mem[idx] <= (idx+1) truncated to DATA_W; idx <= idx+1.
  - When idx==DEPTH-1, that write completes, then state<=RUN and init_done<=1.
- Init latency: exactly DEPTH edges with rst low after reset release. For defaults, mem = {1,2,...,8} and init_done rises on the 8th edge.
- INIT write/read rules:
  - regwrite is ignored: no storage change, no queuing, no later replay.
  - read_data1/2 = 0 regardless of address. Reset value of both read outputs is therefore 0.
- RUN writes: regwrite=1 at an edge sets mem[write_reg] <= write_data. regwrite=0 leaves storage unchanged.
- RUN reads: combinational. read_dataN = mem[read_regN].
- Bypass in RUN: if regwrite=1 and write_reg==read_regN in the same cycle, read_dataN = write_data (new value visible before the edge). Both ports bypass independently; both can bypass at once when both addresses match.
- Both read ports may address the same register; each returns the same value.
- rst asserted during RUN or mid-INIT: an in-flight regwrite that same edge is dropped. Walker restarts from idx=0 and all registers are rewritten. init_done falls on that edge.
- Storage is not cleared by rst. Only the walker rewrites it.
- No latches. Storage is written only from the single clocked process.
- Width rule: init value idx+1 wraps modulo 2**DATA_W. For example, DATA_W=4, ADDR_W=4 gives reg 15 = 0.

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired zero: read_dataN = 0 when read_regN==0, including under bypass.
  - Writes to address 0 are discarded.
  - The walker writes 0 to mem[0]; other registers still get idx+1.
- Undefined: register 0 is an ordinary register (init value 1, writable, bypassable).

Test Plan:
- Reset then init: rst=1 for 2 cycles, then release; sample each cycle. Required: init_done=0 for 7 edges and 1 after the 8th. After that, reads of regs 0..7 return 1..8. Read outputs are 0 throughout INIT.
- Write then read: in RUN, write reg 5 = 0xA5, then write reg 2 = 0x3C. Required: read_reg1=5 gives 0xA5 and read_reg2=2 gives 0x3C; all other registers are unchanged.
- Bypass: in RUN, regwrite=1, write_reg=3, write_data=0x77, read_reg1=3, read_reg2=3. Required: both read 0x77 before the edge and after it. With regwrite=0 the same setup reads the old value 4.
- Write during INIT: assert regwrite with write_reg=6, write_data=0xFF on the 3rd INIT cycle. Required: after init_done, reg 6 reads 7.
- Reset mid-RUN: write reg 1=0x55, then assert rst for 1 cycle while regwrite=1, write_reg=4, write_data=0x99. Required: init_done drops on that edge; after 8 further edges reg 1 reads 2 and reg 4 reads 5.
- REGFILE_ZERO_REG_EN defined: write reg 0=0x12 with read_reg1=0. Required: read_data1=0 during and after the write; the other init values are unchanged.

Source files
------------

// File: rtl/regfile_param_if.sv
// regfile_param_if: register-file access bus between decode/writeback (master)
// and the register file (slave).
interface regfile_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              regwrite;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              init_done;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, regwrite,
    input  read_data1, read_data2, init_done
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, regwrite,
    output read_data1, read_data2, init_done
  );
endinterface

// File: rtl/regfile_param.sv
// regfile_param: parametric 2R1W register file with write-to-read bypass and a
// sequential reset-time init walker. Define REGFILE_ZERO_REG_EN to hardwire reg 0 to zero.
module regfile_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  regfile_param_if.slave rf
);
  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic              r_init_done;
  logic              w_done_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_idx       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_init_done <= w_done_nxt;
    end
  end

  // Next state and the single storage write port (walker in INIT, bus in RUN)
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = r_init_done;
    w_we        = 1'b0;
    w_waddr     = '0;
    w_wdata     = '0;
    case (r_state)
      ST_INIT: begin
        w_we      = 1'b1;
        w_waddr   = r_idx;
        w_wdata   = DATA_W'(32'(r_idx) + 32'd1);
`ifdef REGFILE_ZERO_REG_EN
        if (r_idx == '0) w_wdata = '0;
`endif
        w_idx_nxt = r_idx + ADDR_W'(1);
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_RUN;
          w_done_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        w_we    = rf.regwrite;
        w_waddr = rf.write_reg;
        w_wdata = rf.write_data;
`ifdef REGFILE_ZERO_REG_EN
        if (rf.write_reg == '0) w_we = 1'b0;
`endif
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Storage is never cleared by reset; a reset edge only suppresses the write
  always_ff @(posedge clk) begin
    if (!rst && w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Combinational reads with same-cycle write bypass; zero while initialising
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (r_state == ST_RUN) begin
      w_rd1 = (rf.regwrite && (rf.write_reg == rf.read_reg1)) ? rf.write_data : r_mem[rf.read_reg1];
      w_rd2 = (rf.regwrite && (rf.write_reg == rf.read_reg2)) ? rf.write_data : r_mem[rf.read_reg2];
`ifdef REGFILE_ZERO_REG_EN
      if (rf.read_reg1 == '0) w_rd1 = '0;
      if (rf.read_reg2 == '0) w_rd2 = '0;
`endif
    end
  end

  assign rf.read_data1 = w_rd1;
  assign rf.read_data2 = w_rd2;
  assign rf.init_done  = r_init_done;

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed stimulus pushes hand-computed expectations into a
// scoreboard queue; a negedge monitor pops and compares against the DUT.
module tb_regfile_param;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  typedef struct {
    int          kind;   // 0: read_data1, 1: read_data2, 2: init_done
    logic [DW-1:0] exp;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb_q[$];

  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) rf_if ();

  regfile_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int r);
`ifdef REGFILE_ZERO_REG_EN
    if (r == 0) return '0;
`endif
    return DW'(r + 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [DW-1:0] v, input string tag);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic set_rd(input int r1, input int r2);
    rf_if.read_reg1 = AW'(r1);
    rf_if.read_reg2 = AW'(r2);
  endtask

  task automatic set_wr(input logic we, input int a, input logic [DW-1:0] d);
    rf_if.regwrite   = we;
    rf_if.write_reg  = AW'(a);
    rf_if.write_data = d;
  endtask

  // Monitor: compare every expectation queued for the current cycle
  always @(negedge clk) begin
    exp_t          e;
    logic [DW-1:0] act;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        0:       act = rf_if.read_data1;
        1:       act = rf_if.read_data2;
        default: act = DW'(rf_if.init_done);
      endcase
      n_total++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", e.tag, act, e.exp);
    end
  end

  initial begin
    set_wr(1'b0, 0, '0);
    set_rd(0, 0);

    // Reset held for two edges
    step(); step();
    set_rd(3, 7);
    push(0, '0, "reset_rd1");
    push(1, '0, "reset_rd2");
    push(2, '0, "reset_done");
    rst = 1'b0;

    // Init walk; regwrite to reg 6 during the 3rd INIT edge must be ignored
    for (int e = 1; e <= 8; e++) begin
      step();
      set_wr(e == 2, 6, 8'hFF);
      set_rd(6, 0);
      push(2, DW'(e == 8), $sformatf("init_done_e%0d", e));
      if (e < 8) begin
        push(0, '0, $sformatf("init_rd1_e%0d", e));
        push(1, '0, $sformatf("init_rd2_e%0d", e));
      end else begin
        push(0, init_val(6), "reg6_ignored_init_wr");
      end
    end

    // All init values on both ports
    for (int r = 0; r < 8; r++) begin
      step();
      set_rd(r, 7 - r);
      push(0, init_val(r), $sformatf("init_val_p1_r%0d", r));
      push(1, init_val(7 - r), $sformatf("init_val_p2_r%0d", 7 - r));
    end

    // Write then read
    step(); set_wr(1'b1, 5, 8'hA5); set_rd(5, 5);
    push(0, 8'hA5, "wr5_bypass");
    step(); set_wr(1'b1, 2, 8'h3C); set_rd(5, 2);
    push(0, 8'hA5, "wr5_stored");
    push(1, 8'h3C, "wr2_bypass");
    step(); set_wr(1'b0, 2, 8'h00); set_rd(5, 2);
    push(0, 8'hA5, "rd5");
    push(1, 8'h3C, "rd2");
    for (int r = 0; r < 8; r++) begin
      if (r != 2 && r != 5) begin
        step(); set_rd(r, r);
        push(0, init_val(r), $sformatf("unchanged_r%0d", r));
      end
    end

    // Bypass on both ports, then the stored value after the edge
    step(); set_wr(1'b0, 3, 8'h77); set_rd(3, 3);
    push(0, 8'h04, "no_bypass_p1");
    push(1, 8'h04, "no_bypass_p2");
    step(); set_wr(1'b1, 3, 8'h77);
    push(0, 8'h77, "bypass_p1");
    push(1, 8'h77, "bypass_p2");
    step(); set_wr(1'b0, 3, 8'h00);
    push(0, 8'h77, "after_wr3_p1");
    push(1, 8'h77, "after_wr3_p2");

    // Reset mid-RUN drops the in-flight write and reruns the walker
    step(); set_wr(1'b1, 1, 8'h55); set_rd(1, 4);
    step(); set_wr(1'b1, 4, 8'h99); rst = 1'b1;
    push(0, 8'h55, "wr1_stored");
    step(); rst = 1'b0; set_wr(1'b0, 0, '0);
    push(2, '0, "rst_run_done_drop");
    push(0, '0, "rst_run_rd_zero");
    for (int e = 1; e <= 8; e++) begin
      step();
      push(2, DW'(e == 8), $sformatf("reinit_done_e%0d", e));
    end
    push(0, init_val(1), "reinit_reg1");
    push(1, init_val(4), "reinit_reg4");
    step(); set_rd(3, 5);
    push(0, init_val(3), "reinit_reg3");
    push(1, init_val(5), "reinit_reg5");

`ifdef REGFILE_ZERO_REG_EN
    // Register 0 hardwired zero, even under bypass
    step(); set_wr(1'b1, 0, 8'h12); set_rd(0, 1);
    push(0, '0, "zero_reg_bypass");
    push(1, 8'h02, "zero_reg_other");
    step(); set_wr(1'b0, 0, '0);
    push(0, '0, "zero_reg_after");
    push(1, 8'h02, "zero_reg_other_after");
`else
    // Register 0 is ordinary: writable and bypassable
    step(); set_wr(1'b1, 0, 8'h12); set_rd(0, 1);
    push(0, 8'h12, "reg0_bypass");
    push(1, 8'h02, "reg0_other");
    step(); set_wr(1'b0, 0, '0);
    push(0, 8'h12, "reg0_after");
`endif

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) step();
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
